// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters burst up to MAX_BURST beats
// each into one shared FIFO write port, with a free-running push counter.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 64,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       w_valid,
  output logic [WIDTH-1:0]           data_in,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [15:0]                push_count
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e          state_q;
  logic [IW-1:0]   g_q, last_q;
  logic [BW-1:0]   bcnt_q;
  logic [15:0]     pcnt_q;

  logic            accept, last_beat, rel, any_req;
  logic [IW-1:0]   arb_base, nxt_g, idx;

  assign busy       = (state_q == GRANT);
  assign grant_id   = busy ? g_q : '0;
  assign w_valid    = busy & req_valid[g_q];
  assign data_in    = w_valid ? req_data[int'(g_q)*WIDTH +: WIDTH] : '0;
  assign push_count = pcnt_q;

  assign any_req   = |req_valid;
  assign accept    = w_valid & ~fifo_full;
  assign last_beat = (bcnt_q == BW'(MAX_BURST-1));
  assign rel       = busy & (~req_valid[g_q] | (accept & last_beat));

  genvar k;
  generate
    for (k = 0; k < NUM_REQ; k++) begin : g_rdy
      assign req_ready[k] = busy & (g_q == IW'(k)) & ~fifo_full;
    end
  endgenerate

  // Search starts just after the releasing owner (or last owner when idle), so
  // the previous owner only wins again when nobody else is asking.
  assign arb_base = busy ? g_q : last_q;

  always_comb begin
    nxt_g = '0;
    idx   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IW'((int'(arb_base) + i) % NUM_REQ);
      if (req_valid[idx]) nxt_g = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= '0;
      bcnt_q  <= '0;
      last_q  <= IW'(NUM_REQ-1);
      pcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= GRANT;
            g_q     <= nxt_g;
            bcnt_q  <= '0;
          end
        end
        GRANT: begin
          if (accept) pcnt_q <= pcnt_q + 16'd1;
          if (rel) begin
            last_q <= g_q;
            bcnt_q <= '0;
            if (any_req) g_q <= nxt_g;
            else         state_q <= IDLE;
          end else if (accept) begin
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64: data width of each requester and of the FIFO write port.
REQ-002 The block SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-003 The block SHALL have parameter MAX_BURST, default 4: maximum accepted beats per grant (1..16).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, on ports clk and rst_n.
REQ-005 clk  in  1  system clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req_valid  in  NUM_REQ  per-requester write request; bit k belongs to requester k.
REQ-008 req_data  in  NUM_REQ*WIDTH  per-requester data; requester k occupies bits [k*WIDTH +: WIDTH].
REQ-009 req_ready  out  NUM_REQ  per-requester accept; a beat transfers when req_valid[k] & req_ready[k].
REQ-010 fifo_full  in  1  full flag from the shared FIFO.
REQ-011 w_valid  out  1  FIFO write strobe; the FIFO pushes when w_valid & !fifo_full.
REQ-012 data_in  out  WIDTH  FIFO write data.
REQ-013 grant_id  out  clog2(NUM_REQ)  index of the current owner; 0 when idle.
REQ-014 busy  out  1  high while in GRANT state.
REQ-015 push_count  out  16  running count of beats pushed into the FIFO; wraps 0xFFFF->0x0000.

Function
REQ-016 The FSM SHALL have two states: IDLE and GRANT; owner register g; burst counter bcnt (0..MAX_BURST-1); round-robin pointer last.
REQ-017 IDLE: w_valid=0, req_ready=0, busy=0, grant_id=0.
REQ-018 IDLE with any req_valid bit set: at the next edge, go to GRANT with g = first valid index searching last+1, last+2, ... modulo NUM_REQ; bcnt=0 (one-cycle arbitration latency).
REQ-019 GRANT: w_valid = req_valid[g]; data_in = req_data[g]; req_ready[g] = !fifo_full; all other req_ready bits 0; busy=1; grant_id=g.
REQ-020 Accepted beat = GRANT & req_valid[g] & !fifo_full; on each accepted beat bcnt increments and push_count increments by 1.
REQ-021 fifo_full high in GRANT: no beat accepted; bcnt, g and push_count hold; no timeout; grant is kept.
REQ-022 Release SHALL occur at the edge where (an accepted beat takes place and bcnt==MAX_BURST-1) or req_valid[g]==0.
REQ-023 On release: last <= g; if any req_valid bit is set in that cycle, go directly to GRANT with the next owner chosen by the REQ-018 search from g+1, bcnt=0, no IDLE gap; otherwise go to IDLE.
REQ-024 The releasing owner SHALL be selected by that search only if it is valid and no other requester is valid (it is last in priority).
REQ-025 Requests are sampled only at arbitration edges; requests arriving mid-burst wait for release.
REQ-026 data_in SHALL be 0 whenever w_valid is 0.
REQ-027 With a single continuously-valid requester, bursts SHALL repeat back-to-back with no bubble.

Reset
REQ-028 On rst_n low, immediately and asynchronously: state=IDLE, g=0, bcnt=0, last=NUM_REQ-1 (requester 0 has first priority), push_count=0, all outputs 0.
REQ-029 Reset asserted mid-burst SHALL discard the burst; no partial-state retention.

Verification
REQ-030 Reset: req_valid=0001 asserted at cycle t after reset release -> grant_id=0, busy=1, req_ready=0001, w_valid=1 at t+1.
REQ-031 Round robin: req_valid=1111 held, fifo_full=0 -> owners 0,1,2,3,0 with 4 beats each, no idle cycle, push_count=16 after 16 GRANT cycles.
REQ-032 Back-pressure: fifo_full=1 for 3 cycles after beat 2 of owner 0 -> req_ready[0]=0, w_valid=1, push_count frozen; owner 0 then completes exactly 4 beats before grant moves on.
REQ-033 Early release: owner 1 drops req_valid after 2 beats while req_valid[3]=1 -> grant_id=3 on the next cycle, bcnt restarts at 0.
REQ-034 Reset mid-burst: rst_n low during beat 2 of owner 2 -> all outputs 0 at once; after release with req_valid=0110, the first grant goes to requester 1.
REQ-035 Counter wrap: push_count preloaded to 0xFFFF via 65535 beats -> next beat yields 0x0000; the FIFO model receives every beat in order per requester.
